// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC register, one-outstanding fetch over valid/ready memory, hands words to decode.
// Optional IFU_STATS_EN adds fetch/stall counters.
module ifu_fetch #(
   parameter int unsigned     XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000_0000_8000_0000)
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            req_valid,
   input  logic            req_ready,
   output logic [XLEN-1:0] req_addr,
   input  logic            resp_valid,
   input  logic [31:0]     resp_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     Instr,
   output logic [XLEN-1:0] Instr_PC,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
`ifdef IFU_STATS_EN
   ,
   output logic [63:0]     fetch_cnt,
   output logic [63:0]     stall_cnt
`endif
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            kill_q, kill_d;
   logic            capture;
   logic [31:0]     instr_q;
   logic [XLEN-1:0] instr_pc_q;
   logic [XLEN-1:0] target;

   assign target    = redirect_pc & ~XLEN'(3);
   assign req_valid = (state_q == S_REQ);
   assign out_valid = (state_q == S_HOLD);
   assign req_addr  = pc_q;
   assign Instr     = instr_q;
   assign Instr_PC  = instr_pc_q;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      kill_d  = kill_q;
      capture = 1'b0;
      unique case (state_q)
         S_REQ: begin
            if (req_ready) begin
               state_d = S_WAIT;
               // request just issued carries the old PC, so a redirect now makes it stale
               kill_d  = redirect_valid;
            end
            if (redirect_valid) pc_d = target;
         end
         S_WAIT: begin
            if (resp_valid) begin
               kill_d = 1'b0;
               if (redirect_valid || kill_q) begin
                  state_d = S_REQ;
               end else begin
                  capture = 1'b1;
                  state_d = S_HOLD;
               end
            end else if (redirect_valid) begin
               kill_d = 1'b1;
            end
            if (redirect_valid) pc_d = target;
         end
         S_HOLD: begin
            if (redirect_valid) begin
               pc_d    = target;
               state_d = S_REQ;
            end else if (out_ready) begin
               pc_d    = pc_q + XLEN'(4);
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         kill_q     <= 1'b0;
         instr_q    <= '0;
         instr_pc_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         kill_q  <= kill_d;
         if (capture) begin
            instr_q    <= resp_data;
            instr_pc_q <= pc_q;
         end
      end
   end

`ifdef IFU_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else if (state_q == S_HOLD) begin
         if (out_ready) fetch_cnt <= fetch_cnt + 64'd1;
         else           stall_cnt <= stall_cnt + 64'd1;
      end
   end
`endif

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit directly upstream of the decode/immediate-generation stage.
- Holds the PC and issues one 32-bit instruction fetch per instruction over a valid/ready memory interface.
- Presents the fetched word and its PC to decode with a valid/ready handshake.
- Accepts PC redirects from execute (branch/jump targets computed with the sign-extended immediates). Any in-flight fetch made stale by a redirect is killed.

Parameters:
- XLEN, 64, PC and address width.
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  output  1  fetch request valid.
- req_ready  input  1  memory accepts request.
- req_addr  output  XLEN  fetch address; equals current PC.
- resp_valid  input  1  fetch data valid; memory never back-pressured.
- resp_data  input  32  fetched instruction word.
- out_valid  output  1  Instr/Instr_PC valid to decode.
- out_ready  input  1  decode accepts instruction.
- Instr  output  32  instruction to decode.
- Instr_PC  output  XLEN  PC of Instr.
- redirect_valid  input  1  load new PC (from execute).
- redirect_pc  input  XLEN  new PC; bits [1:0] forced to 0 on load.

Behaviour:
- Reset: synchronous, active-low (rst_n sampled at clk rising edge). Effects:
  - state=REQ, pc=RESET_PC, kill=0, Instr=0, Instr_PC=0.
  - Outputs: out_valid=0; req_valid=1 in the first cycle after rst_n deasserts.
  - Reset mid-operation abandons any outstanding request; a late resp_valid while in REQ is ignored.
- Outputs are decoded from registered state only; no combinational path from inputs to outputs:
  - req_valid = (state==REQ).
  - out_valid = (state==HOLD).
  - req_addr = pc.
- REQ:
  - req_valid && req_ready -> WAIT.
  - redirect_valid -> pc<=redirect_pc.
  - Both in the same cycle -> go WAIT, pc<=redirect_pc, kill<=1.
- WAIT:
  - resp_valid && !kill -> Instr<=resp_data, Instr_PC<=pc, go HOLD.
  - resp_valid && kill -> discard data, kill<=0, go REQ.
  - redirect_valid -> pc<=redirect_pc, kill<=1. If resp_valid arrives in the same cycle, that response is discarded and the FSM goes REQ with kill=0.
- HOLD:
  - Instr and Instr_PC are stable while out_valid && !out_ready.
  - out_ready && !redirect_valid -> pc<=pc+4, go REQ.
  - redirect_valid -> pc<=redirect_pc, go REQ, regardless of out_ready. A same-cycle out handshake still counts; downstream is responsible for flushing it.
- Arithmetic and ordering:
  - pc+4 wraps modulo 2^XLEN; 0xFFFF_FFFF_FFFF_FFFC -> 0.
  - Sequential fetches are strictly in order; at most one request outstanding.
- Latency and throughput:
  - Request handshake in cycle N, response in N+k (k>=1), out_valid in N+k+1.
  - Peak throughput is 1 instruction per 3 cycles.
- Back-to-back redirects: the last one wins; kill is a single bit.
  - Assumption on the memory side: a killed request still returns exactly one response.

Optional Feature:
- Macro IFU_STATS_EN adds two output ports:
  - fetch_cnt (64): increments on each out handshake.
  - stall_cnt (64): increments each cycle with out_valid && !out_ready.
  - Both counters reset to 0 and wrap.
- Without IFU_STATS_EN, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, req_ready=1, memory returns 0x00000013 after 1 cycle, out_ready=1:
  - First req_addr=0x80000000; out_valid at cycle 3 with Instr=0x13, Instr_PC=0x80000000.
  - Next req_addr=0x80000004.
- Back-pressure: out_ready=0 for 5 cycles in HOLD:
  - Instr/Instr_PC held; no new request.
  - After out_ready=1, req_addr=PC+4.
- Redirect during WAIT to 0x80000103:
  - Stale response dropped; out_valid stays 0.
  - Next req_addr=0x80000100; delivered Instr_PC=0x80000100.
- Redirect and req handshake in the same cycle:
  - The killed response is never presented.
  - Following request uses the redirect target.
- PC=0xFFFFFFFFFFFFFFFC consumed:
  - Next req_addr=0x0.
- Assert rst_n=0 while in WAIT:
  - Next cycle req_valid=1, req_addr=RESET_PC, out_valid=0.
  - The late response is ignored.
  - With IFU_STATS_EN: counters return to 0.
